// File: rtl/maxpool_stream_layer.sv
// ============================================================================
// Module      : maxpool_stream_layer
// Description : Streaming non-overlapping max-pool over CH channels with
//               valid/ready handshake and frame-end partial-window flush.
//               Optional argmax output enabled by MAXPOOL_ARGMAX_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maxpool_stream_layer #(
  parameter int CH     = 8,
  parameter int W      = 8,
  parameter int POOL_K = 5,
  parameter int SIGNED = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH*W-1:0] in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH*W-1:0] out_data,
  output logic            out_last
`ifdef MAXPOOL_ARGMAX_EN
  ,
  output logic [CH*6-1:0] out_idx
`endif
);

  localparam int CNT_W = (POOL_K > 1) ? $clog2(POOL_K) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POOL_K - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH*W-1:0]  acc_q, acc_d;
  logic [CH*W-1:0]  out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [CH*W-1:0]  acc_new;
  logic [W-1:0]     in_c;
  logic [W-1:0]     acc_c;
  logic             gt_c;
  logic             accept;
  logic             close;
`ifdef MAXPOOL_ARGMAX_EN
  logic [CH*6-1:0]  idx_q, idx_d;
  logic [CH*6-1:0]  out_idx_q, out_idx_d;
  logic [CH*6-1:0]  idx_new;
`endif

  assign in_ready  = en & ~rst & (~out_valid_q | out_ready);
  assign accept    = in_valid & in_ready;
  assign close     = accept & ((cnt_q == CNT_LAST) | in_last);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
`ifdef MAXPOOL_ARGMAX_EN
  assign out_idx   = out_idx_q;
`endif

  // Strict greater-than keeps the earliest tap on ties; tap 0 always loads.
  always_comb begin
    acc_new = acc_q;
    in_c    = '0;
    acc_c   = '0;
    gt_c    = 1'b0;
`ifdef MAXPOOL_ARGMAX_EN
    idx_new = idx_q;
`endif
    for (int c = 0; c < CH; c++) begin
      in_c  = in_data[c*W +: W];
      acc_c = acc_q[c*W +: W];
      gt_c  = (SIGNED != 0) ? ($signed(in_c) > $signed(acc_c)) : (in_c > acc_c);
      if ((cnt_q == '0) || gt_c) begin
        acc_new[c*W +: W] = in_c;
`ifdef MAXPOOL_ARGMAX_EN
        idx_new[c*6 +: 6] = 6'(cnt_q);
`endif
      end
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
`ifdef MAXPOOL_ARGMAX_EN
    idx_d       = idx_q;
    out_idx_d   = out_idx_q;
`endif
    // With en low nothing moves, including retirement of a pending vector.
    if (en) begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        acc_d = acc_new;
`ifdef MAXPOOL_ARGMAX_EN
        idx_d = idx_new;
`endif
        cnt_d = close ? '0 : cnt_q + CNT_W'(1);
        if (close) begin
          out_data_d  = acc_new;
          out_valid_d = 1'b1;
          out_last_d  = in_last;
`ifdef MAXPOOL_ARGMAX_EN
          out_idx_d   = idx_new;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef MAXPOOL_ARGMAX_EN
      idx_q       <= '0;
      out_idx_q   <= '0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
`ifdef MAXPOOL_ARGMAX_EN
      idx_q       <= idx_d;
      out_idx_q   <= out_idx_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_maxpool_stream_layer.sv
// ============================================================================
// Module      : tb_maxpool_stream_layer
// Description : Directed self-checking bench for maxpool_stream_layer
//               (unsigned instance plus a SIGNED=1 twin on shared inputs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maxpool_stream_layer;

  localparam int CH = 8;
  localparam int W  = 8;
  localparam int K  = 5;

  logic          clk = 1'b0;
  logic          rst, en, in_valid, in_last, out_ready;
  logic [CH*W-1:0] in_data;
  logic          in_ready, out_valid, out_last;
  logic [CH*W-1:0] out_data;
  logic          in_ready_s, out_valid_s, out_last_s;
  logic [CH*W-1:0] out_data_s;
`ifdef MAXPOOL_ARGMAX_EN
  logic [CH*6-1:0] out_idx, out_idx_s;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  maxpool_stream_layer #(.CH(CH), .W(W), .POOL_K(K), .SIGNED(0)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
`ifdef MAXPOOL_ARGMAX_EN
    , .out_idx(out_idx)
`endif
  );

  maxpool_stream_layer #(.CH(CH), .W(W), .POOL_K(K), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_data(out_data_s), .out_last(out_last_s)
`ifdef MAXPOOL_ARGMAX_EN
    , .out_idx(out_idx_s)
`endif
  );

  typedef struct {
    logic [39:0] taps;      // tap i at [i*8 +: 8]
    int          n;
    logic        last;
    logic [7:0]  exp_max;
    logic        exp_last;
    logic [5:0]  exp_idx;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic beat(input logic [CH*W-1:0] data, input logic last);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    int vcount;
    tbl[0] = '{{8'd7, 8'd9, 8'd2, 8'd9, 8'd3},       5, 1'b0, 8'd9,    1'b0, 6'd1};
    tbl[1] = '{{8'd5, 8'd4, 8'd3, 8'd2, 8'd1},       5, 1'b0, 8'd5,    1'b0, 6'd4};
    tbl[2] = '{{24'd0, 8'd3, 8'd8},                  2, 1'b1, 8'd8,    1'b1, 6'd0};
    tbl[3] = '{{32'd0, 8'hFF},                       5, 1'b0, 8'hFF,   1'b0, 6'd0};
    tbl[4] = '{{24'd0, 8'd20, 8'd10},                2, 1'b1, 8'd20,   1'b1, 6'd1};
    tbl[5] = '{{32'd0, 8'h42},                       1, 1'b1, 8'h42,   1'b1, 6'd0};
    tbl[6] = '{{8'd7, 8'd7, 8'd7, 8'd7, 8'd7},       5, 1'b0, 8'd7,    1'b0, 6'd0};
    tbl[7] = '{{8'd9, 8'd8, 8'd7, 8'd6, 8'd5},       5, 1'b1, 8'd9,    1'b1, 6'd4};
    tbl[8] = '{40'd0,                                5, 1'b0, 8'd0,    1'b0, 6'd0};

    rst = 1'b1; en = 1'b1; in_valid = 1'b1; in_last = 1'b0; out_ready = 1'b1;
    in_data = {8{8'hAB}};

    // Reset held two cycles with a valid beat presented.
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Table-driven windows; the last beat of each entry closes a window.
    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < tbl[v].n; i++) begin
        beat({CH{tbl[v].taps[i*8 +: 8]}}, tbl[v].last && (i == tbl[v].n - 1));
        if (i == tbl[v].n - 2)
          chk($sformatf("v%0d_open_valid", v), 64'(out_valid), 64'd0);
      end
      chk($sformatf("v%0d_valid", v), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_data", v), out_data, {CH{tbl[v].exp_max}});
      chk($sformatf("v%0d_last", v), 64'(out_last), 64'(tbl[v].exp_last));
`ifdef MAXPOOL_ARGMAX_EN
      chk($sformatf("v%0d_idx", v), out_idx, {CH{tbl[v].exp_idx}});
`endif
    end

    // Signed vs unsigned compare on channel 1.
    beat({48'd0, 8'h80, 8'h00}, 1'b0);
    beat({48'd0, 8'hF0, 8'h00}, 1'b0);
    beat({48'd0, 8'h05, 8'h00}, 1'b0);
    beat({48'd0, 8'hFF, 8'h00}, 1'b0);
    beat({48'd0, 8'h10, 8'h00}, 1'b0);
    chk("unsigned_ch1", out_data, 64'h0000_0000_0000_FF00);
    chk("signed_ch1", out_data_s, 64'h0000_0000_0000_1000);
    chk("signed_valid", 64'(out_valid_s), 64'd1);
`ifdef MAXPOOL_ARGMAX_EN
    chk("unsigned_idx_ch1", 64'(out_idx[11:6]), 64'd3);
    chk("signed_idx_ch1", 64'(out_idx_s[11:6]), 64'd4);
`endif

    // Backpressure: a pending vector stalls the input for 8 cycles.
    beat({CH{8'd10}}, 1'b0);
    beat({CH{8'd50}}, 1'b0);
    beat({CH{8'd20}}, 1'b0);
    beat({CH{8'd30}}, 1'b0);
    beat({CH{8'd40}}, 1'b0);
    chk("bp_first_data", out_data, {CH{8'd50}});
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {CH{8'h99}};
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_data", out_data, {CH{8'd50}});
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    beat({CH{8'h99}}, 1'b0);
    beat({CH{8'd1}}, 1'b0);
    beat({CH{8'd2}}, 1'b0);
    beat({CH{8'd3}}, 1'b0);
    beat({CH{8'd4}}, 1'b0);
    chk("bp_no_loss", out_data, {CH{8'h99}});

    // Continuous stream: one vector per 5 beats, input never stalls.
    vcount = 0;
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1;
      in_data  = {CH{8'(i)}};
      #1;
      if (!in_ready) begin
        errors++;
        $display("FAIL stream_ready: got 0 expected 1 at beat %0d", i);
      end
      checks++;
      @(posedge clk);
      #1;
      if (out_valid) vcount++;
    end
    in_valid = 1'b0;
    chk("stream_vectors", 64'(vcount), 64'd3);
    chk("stream_last_data", out_data, {CH{8'd14}});

    // en=0 freezes a pending vector even with out_ready high.
    en = 1'b0;
    in_valid = 1'b1;
    repeat (3) begin
      #1;
      chk("en0_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      chk("en0_hold_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("en1_retire", 64'(out_valid), 64'd0);

    // Reset mid-window discards the partial window.
    beat({CH{8'hEE}}, 1'b0);
    beat({CH{8'hEE}}, 1'b0);
    beat({CH{8'hEE}}, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    beat({CH{8'd1}}, 1'b0);
    beat({CH{8'd2}}, 1'b0);
    beat({CH{8'd3}}, 1'b0);
    beat({CH{8'd4}}, 1'b0);
    chk("midrst_open_valid", 64'(out_valid), 64'd0);
    beat({CH{8'd5}}, 1'b0);
    chk("midrst_valid_close", 64'(out_valid), 64'd1);
    chk("midrst_data", out_data, {CH{8'd5}});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
